dm_if_mem_arbiter: RTL and testbench
====================================

Name: dm_if_mem_arbiter

Overview:
- Arbitrates one shared single-port synchronous memory between instruction fetch (IF) and the EX-stage data access (dm_enable/dm_write from the ALU, address = ALU out).
- Sequences each access with a fixed-latency FSM and registers the returned read data.
- Drives a stall to the pipeline until the pending access completes.
- Sits between the IF/EX stages and the memory macro.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the mem_cs cycle; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_enable  in  1  data access request, level (from ALU DM_enable)
- dm_write  in  1  1=store, 0=load (from ALU DM_write)
- dm_addr  in  ADDR_W  data address (ALU out)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- mem_cs  out  1  memory chip select, one-cycle pulse per access
- mem_we  out  1  memory write enable, qualified by mem_cs
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_cs cycle
- pipe_stall  out  1  combinational: (dm_enable & ~dm_ready) | (if_req & ~if_ready)

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - State returns to IDLE; last_dm=0; wait counter=0.
  - mem_cs, mem_we, if_ready, dm_ready = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Any in-flight access is dropped with no ready pulse.
  - mem_cs deasserts immediately, without waiting for a clock edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the requests.
  - If only one requester is active, grant it.
  - If both are active, grant DM unless last_dm=1, in which case grant IF (alternating round-robin; neither side starves).
  - On grant, latch owner, address, write data and write flag (write flag = dm_write for DM, 0 for IF), then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - mem_cs=1; mem_we=latched write flag; mem_addr and mem_wdata carry the latched values.
  - Load counter with MEM_LAT-1 and go to WAIT.
  - last_dm updates to (owner==DM).
- WAIT:
  - mem_cs=0; counter decrements.
  - On the cycle where counter==0: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), then go to RESP.
- RESP (1 cycle):
  - Pulse owner's ready=1; go to IDLE.
  - No new grant is taken in RESP, so the requester can drop or replace its request on the following edge.
- Latency: request seen in IDLE at cycle T gives mem_cs at T+1 and ready at T+2+MEM_LAT. With MEM_LAT=2 this is T+4. Stores use the same timing.
- Requests changing or dropping while not granted are ignored; the latched values are used for the whole access.
- A request dropped after grant still completes the access and pulses ready (harmless to the requester).
- rdata registers hold their last value between accesses.
- mem_addr and mem_wdata hold their last latched value outside ISSUE.

Decomposition:
- Package dm_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, ISSUE, WAIT, RESP}
  - typedef enum owner_e {OWN_IF, OWN_DM}
  - localparam for the counter width (4 bits)
- One natural sub-module: arb_wait_counter, a loadable down-counter with zero flag and async active-low reset.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, memory model returns 0x00A00093 two cycles after cs -> mem_cs at T+1 with mem_we=0, if_ready pulse at T+4 with if_rdata=0x00A00093, pipe_stall=1 during T..T+3 and 0 at T+4.
- Store: dm_enable=1, dm_write=1, dm_addr=0x200, dm_wdata=0xDEADBEEF -> single mem_cs cycle with mem_we=1, addr 0x200, data 0xDEADBEEF; dm_ready at T+4; dm_rdata unchanged.
- Contention: if_req=1 and dm_enable=1 (load 0x204) held together -> DM granted first, then IF, then DM again (alternating); each ready exactly once per access; no two mem_cs cycles closer than MEM_LAT+2 apart.
- Request change after grant: dm_addr switches 0x204->0x300 during WAIT -> mem_addr stays 0x204 for the access; the new address is served only after re-request in IDLE.
- Reset mid-op: assert rst=0 during WAIT -> mem_cs, readies and rdata go to 0 without a clock edge; after release, no ready pulse for the dropped access and the next request is served from IDLE.
- MEM_LAT=1 build: fetch -> if_ready at T+3; data captured on the cycle right after mem_cs.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types for the IF/DM memory arbiter: FSM states, access owner, wait-counter width.
package dm_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that times the memory read latency; zero marks the data-valid cycle.
module arb_wait_counter
    import dm_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dm_if_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and EX-stage data access,
// alternating grants under contention and stalling the pipeline until each access returns.
module dm_if_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_enable,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e state;
    owner_e     owner;
    logic       last_dm;
    logic       wr_flag;
    logic       cnt_zero;

    arb_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (state == ISSUE),
        .dec      ((state == WAIT) && !cnt_zero),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            last_dm   <= 1'b0;
            wr_flag   <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // DM wins a tie unless it had the previous grant
                    if (dm_enable && (!if_req || !last_dm)) begin
                        owner     <= OWN_DM;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        wr_flag   <= dm_write;
                        mem_cs    <= 1'b1;
                        mem_we    <= dm_write;
                        state     <= ISSUE;
                    end else if (if_req) begin
                        owner    <= OWN_IF;
                        mem_addr <= if_addr;
                        wr_flag  <= 1'b0;
                        mem_cs   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_dm <= (owner == OWN_DM);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        if (owner == OWN_DM) begin
                            if (!wr_flag) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pipe_stall = (dm_enable & ~dm_ready) | (if_req & ~if_ready);

endmodule

// File: tb/tb_dm_if_mem_arbiter.sv
// Self-checking bench: directed vector table, reset-abort sequences, a MEM_LAT=1 build,
// and randomized transactions checked against a cycle-timeline model of the arbiter.
module tb_dm_if_mem_arbiter;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_enable, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_cs, mem_we, pipe_stall;

    logic        l1_if_req, l1_dm_enable, l1_dm_write;
    logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
    logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ready, l1_dm_ready, l1_mem_cs, l1_mem_we, l1_pipe_stall;

    always #5 clk = ~clk;

    dm_if_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_enable(dm_enable), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    dm_if_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
        .dm_enable(l1_dm_enable), .dm_write(l1_dm_write), .dm_addr(l1_dm_addr),
        .dm_wdata(l1_dm_wdata), .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
        .mem_cs(l1_mem_cs), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .pipe_stall(l1_pipe_stall)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Initial memory image; word 0x100 holds the instruction used by the fetch checks
    function automatic logic [31:0] memdef(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00A00093 : ((a * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    // Memory macro model: stores land at the cs edge, read data appears L cycles after cs
    bit   [31:0] mem_arr [256];
    bit          mem_wr  [256];
    logic [31:0] rd_pipe [16];
    logic        rd_vld  [16];
    logic [31:0] junk;

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return mem_wr[a[9:2]] ? mem_arr[a[9:2]] : memdef(a);
    endfunction

    always @(posedge clk) begin
        if (mem_cs === 1'b1 && mem_we === 1'b1) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            mem_wr[mem_addr[9:2]]  <= 1'b1;
        end
        rd_pipe[0] <= env_rd(mem_addr);
        rd_vld[0]  <= (mem_cs === 1'b1) && (mem_we === 1'b0);
        for (int i = 1; i < 16; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
        junk <= $urandom;
    end
    assign mem_rdata = (rd_vld[L-1] === 1'b1) ? rd_pipe[L-1] : junk;

    always @(posedge clk) begin
        l1_mem_rdata <= (l1_mem_cs === 1'b1) ? memdef(l1_mem_addr) : $urandom;
    end

    // Reference state: shadow memory, round-robin history, expected held register values
    bit   [31:0] sh_arr [256];
    bit          sh_wr  [256];
    bit          last_dm;
    logic [31:0] exp_if_rd, exp_dm_rd, exp_maddr;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return sh_wr[a[9:2]] ? sh_arr[a[9:2]] : memdef(a);
    endfunction

    // Called just after a rising edge with the arbiter idle; requests drop on their ready cycle.
    task automatic run_txn(input bit wi, input bit wd, input bit wr,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wdat,
                           input logic [31:0] alt_da, input int chg,
                           input int if_cyc, input int dm_cyc);
        int          last_cyc;
        int          if_cs;
        int          dm_cs;
        logic [31:0] if_val;
        logic [31:0] dm_val;
        last_cyc = (if_cyc > dm_cyc) ? if_cyc : dm_cyc;
        if_cs    = wi ? if_cyc - int'(L) - 1 : -1;
        dm_cs    = wd ? dm_cyc - int'(L) - 1 : -1;
        if_val   = ref_rd(ia);
        dm_val   = ref_rd(da);
        if (wd && wr) begin
            sh_arr[da[9:2]] = wdat;
            sh_wr[da[9:2]]  = 1'b1;
        end
        if_req = wi; if_addr = ia;
        dm_enable = wd; dm_write = wr; dm_addr = da; dm_wdata = wdat;
        for (int c = 0; c <= last_cyc; c++) begin
            if (chg > 0 && c == chg) dm_addr = alt_da;
            if (c == if_cs) exp_maddr = ia;
            if (c == dm_cs) exp_maddr = da;
            if (wi && c == if_cyc) exp_if_rd = if_val;
            if (wd && !wr && c == dm_cyc) exp_dm_rd = dm_val;
            @(negedge clk);
            chk($sformatf("ctl{cs,we,ifr,dmr,stall} c%0d", c),
                {mem_cs, mem_we, if_ready, dm_ready, pipe_stall},
                {c == if_cs || c == dm_cs, c == dm_cs && wr, wi && c == if_cyc,
                 wd && c == dm_cyc, (wi && c < if_cyc) || (wd && c < dm_cyc)});
            chk("mem_addr", mem_addr, exp_maddr);
            if (c == dm_cs && wr) chk("mem_wdata", mem_wdata, wdat);
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("dm_rdata", dm_rdata, exp_dm_rd);
            @(posedge clk); #1;
            if (c == if_cyc) if_req = 1'b0;
            if (c == dm_cyc) dm_enable = 1'b0;
        end
        last_dm = wd && (!wi || dm_cyc > if_cyc);
    endtask

    typedef struct {
        bit          wi, wd, wr;
        logic [31:0] ia, da, wdat, alt;
        int          chg, if_cyc, dm_cyc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        32'h0,   0, 4, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 32'h0,        32'h0,   0, 9, 4};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h208, 32'h0,        32'h0,   0, 9, 4};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h200, 32'hDEADBEEF, 32'h0,   0, 0, 4};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h200, 32'h0,        32'h0,   0, 4, 9};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h204, 32'h0,        32'h300, 3, 0, 4};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 32'h0,        32'h0,   0, 0, 4};

        if_req = 0; dm_enable = 0; dm_write = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        l1_if_req = 0; l1_dm_enable = 0; l1_dm_write = 0;
        l1_if_addr = 0; l1_dm_addr = 0; l1_dm_wdata = 0;
        last_dm = 0; exp_if_rd = 0; exp_dm_rd = 0; exp_maddr = 0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst{cs,we,ifr,dmr}", {mem_cs, mem_we, if_ready, dm_ready}, 4'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst dm_rdata", dm_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        foreach (tbl[i])
            run_txn(tbl[i].wi, tbl[i].wd, tbl[i].wr, tbl[i].ia, tbl[i].da, tbl[i].wdat,
                    tbl[i].alt, tbl[i].chg, tbl[i].if_cyc, tbl[i].dm_cyc);

        // Abort a load in ISSUE and then in WAIT; nothing may complete afterwards
        for (int rc = 1; rc <= 2; rc++) begin
            dm_enable = 1'b1; dm_write = 1'b0; dm_addr = 32'h208;
            for (int c = 0; c < rc; c++) begin
                @(posedge clk); #1;
            end
            chk("cs before reset", mem_cs, rc == 1);
            #2 rst = 1'b0;
            #1;
            chk("async rst{cs,we,ifr,dmr}", {mem_cs, mem_we, if_ready, dm_ready}, 4'b0);
            chk("async rst dm_rdata", dm_rdata, 32'h0);
            chk("async rst if_rdata", if_rdata, 32'h0);
            chk("async rst mem_addr", mem_addr, 32'h0);
            dm_enable = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
            last_dm = 0; exp_if_rd = 0; exp_dm_rd = 0; exp_maddr = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                chk("post-rst quiet{cs,ifr,dmr,stall}",
                    {mem_cs, if_ready, dm_ready, pipe_stall}, 4'b0);
                @(posedge clk); #1;
            end
            run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 4, 0);
        end

        // MEM_LAT=1 build: ready two cycles after cs
        l1_if_req = 1'b1; l1_if_addr = 32'h100;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("lat1{cs,ifr,stall} c%0d", c),
                {l1_mem_cs, l1_if_ready, l1_pipe_stall}, {c == 1, c == 3, c < 3});
            if (c == 3) chk("lat1 if_rdata", l1_if_rdata, 32'h00A00093);
            @(posedge clk); #1;
            if (c == 3) l1_if_req = 1'b0;
        end

        // Randomized transactions with idle gaps
        for (int n = 0; n < 40; n++) begin
            int          sel;
            int          gap;
            bit          wi, wd, wr;
            int          ic, dc;
            logic [31:0] ia, da, wdat;
            sel  = int'($urandom_range(0, 2));
            wi   = (sel != 1);
            wd   = (sel != 0);
            wr   = 1'($urandom_range(0, 1));
            ia   = 32'h100 + 32'd4 * $urandom_range(0, 15);
            da   = 32'h200 + 32'd4 * $urandom_range(0, 7);
            wdat = $urandom;
            if (wi && wd) begin
                dc = last_dm ? 2 * int'(L) + 5 : int'(L) + 2;
                ic = last_dm ? int'(L) + 2 : 2 * int'(L) + 5;
            end else begin
                ic = wi ? int'(L) + 2 : 0;
                dc = wd ? int'(L) + 2 : 0;
            end
            run_txn(wi, wd, wr, ia, da, wdat, 32'h0, 0, ic, dc);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("idle{cs,ifr,dmr,stall}", {mem_cs, if_ready, dm_ready, pipe_stall}, 4'b0);
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
